// File: rtl/register_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package register_pkg;

   // Default data values loaded by reset/flush and by preset.
   localparam int unsigned DefResetValue = 0;
   localparam int unsigned DefSetValue   = 1;

   // Width needed to hold a count from 0 to depth inclusive.
   function automatic int unsigned clog2p1(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/register_stage.sv
// One valid/data stage of the elastic pipeline.
module register_stage
   import register_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DefResetValue)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_src_valid,
   input  logic [WIDTH-1:0] i_src_data,
   input  logic             i_flush,
   input  logic             i_preset_en,
   input  logic             i_preset_valid,
   input  logic [WIDTH-1:0] i_preset_value,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   // Next state: preset beats flush beats normal advance; data holds across bubbles.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (i_preset_en) begin
         v_d = i_preset_valid;
         d_d = i_preset_value;
      end else if (i_flush) begin
         v_d = 1'b0;
         d_d = RESET_VALUE;
      end else if (i_load) begin
         v_d = i_src_valid;
         if (i_src_valid) begin
            d_d = i_src_data;
         end
      end
   end

   // Stage registers with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v_q <= 1'b0;
         d_q <= RESET_VALUE;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign o_valid = v_q;
   assign o_data  = d_q;

endmodule

// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapsing,
// flush, preset and occupancy count.
module register_pipe
   import register_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DefResetValue),
   parameter logic [WIDTH-1:0] SET_VALUE   = WIDTH'(DefSetValue)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [WIDTH-1:0]              i_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [WIDTH-1:0]              o_data,
   input  logic                          i_flush,
   input  logic                          i_set,
   output logic [clog2p1(DEPTH)-1:0]     o_count
);

   localparam int unsigned CntW = clog2p1(DEPTH);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [DEPTH:0]   can;
   logic [CntW-1:0]  count;

   // Advance chain: a stage may load if it is empty or the stage after it moves.
   always_comb begin
      can        = '0;
      can[DEPTH] = i_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         can[k] = ~v[k] | can[k+1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_src_in
         assign src_v[k] = i_valid;
         assign src_d[k] = i_data;
      end else begin : g_src_prev
         assign src_v[k] = v[k-1];
         assign src_d[k] = d[k-1];
      end

      register_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .i_clk          (i_clk),
         .i_rst          (i_rst),
         .i_load         (can[k]),
         .i_src_valid    (src_v[k]),
         .i_src_data     (src_d[k]),
         .i_flush        (i_flush),
         .i_preset_en    (i_set),
         .i_preset_valid ((k == DEPTH - 1)),
         .i_preset_value ((k == DEPTH - 1) ? SET_VALUE : RESET_VALUE),
         .o_valid        (v[k]),
         .o_data         (d[k])
      );
   end

   // Occupancy is the popcount of the stage valid bits.
   always_comb begin
      count = '0;
      for (int k = 0; k < DEPTH; k++) begin
         count = count + CntW'(v[k]);
      end
   end

   assign o_ready = can[0] & ~i_set;
   assign o_valid = v[DEPTH-1];
   assign o_data  = d[DEPTH-1];
   assign o_count = count;

endmodule
